// File: rtl/opcode_type.sv
// Shared RV32I opcode definitions: R-type operation kinds and their funct field mapping.
// Used by both the R-type encoder and the matching decoder.
package opcode_type;

  typedef enum logic [3:0] {
    rak_add  = 4'd0,
    rak_sub  = 4'd1,
    rak_sll  = 4'd2,
    rak_slt  = 4'd3,
    rak_sltu = 4'd4,
    rak_xor  = 4'd5,
    rak_srl  = 4'd6,
    rak_sra  = 4'd7,
    rak_or   = 4'd8,
    rak_and  = 4'd9
  } reg_arith_kind_t;

  localparam logic [6:0] OPCODE_OP   = 7'b0110011;
  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef struct packed {
    logic       legal;
    logic [6:0] funct7;
    logic [2:0] funct3;
  } r_fields_t;

  // Encodings outside the ten members come back with legal = 0.
  function automatic r_fields_t rak_fields(input reg_arith_kind_t kind);
    r_fields_t f;
    f.legal  = 1'b1;
    f.funct7 = FUNCT7_BASE;
    f.funct3 = 3'b000;
    case (kind)
      rak_add:  f.funct3 = 3'b000;
      rak_sub:  begin f.funct3 = 3'b000; f.funct7 = FUNCT7_ALT; end
      rak_sll:  f.funct3 = 3'b001;
      rak_slt:  f.funct3 = 3'b010;
      rak_sltu: f.funct3 = 3'b011;
      rak_xor:  f.funct3 = 3'b100;
      rak_srl:  f.funct3 = 3'b101;
      rak_sra:  begin f.funct3 = 3'b101; f.funct7 = FUNCT7_ALT; end
      rak_or:   f.funct3 = 3'b110;
      rak_and:  f.funct3 = 3'b111;
      default:  f.legal  = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/r_type_encoder_if.sv
// Request/response bus of the R-type encoder. Both sides use valid/ready:
// a transfer happens on a rising edge where valid && ready; valid must not depend on ready.
interface r_type_encoder_if;

  logic                         in_valid;
  logic                         in_ready;
  opcode_type::reg_arith_kind_t in_kind;
  logic [4:0]                   in_rd;
  logic [4:0]                   in_rs1;
  logic [4:0]                   in_rs2;
  logic                         out_valid;
  logic                         out_ready;
  logic [31:0]                  out_instr;
  logic [31:0]                  out_addr;

  modport slave (
    input  in_valid, in_kind, in_rd, in_rs1, in_rs2, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );

  modport master (
    output in_valid, in_kind, in_rd, in_rs1, in_rs2, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

endinterface

// File: rtl/r_type_fifo.sv
// Synchronous FIFO with flush; DEPTH must be a power of two so pointers wrap naturally.
// count disambiguates full from empty; rdata reads 0 while empty.
module r_type_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic          empty;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign do_push = push && !full && !flush && !rst;
  assign do_pop  = pop && !empty && !flush && !rst;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/r_type_encoder.sv
// Buffered RV32I R-type encoder: encodes (kind, rd, rs1, rs2) requests and queues each
// word with a sequential byte address. Illegal kinds are consumed, dropped, and flagged in err.
module r_type_encoder
  import opcode_type::*;
#(
  parameter  int          DEPTH     = 4,
  parameter  logic [31:0] BASE_ADDR = 32'h0000_0000,
  localparam int          CW        = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  r_type_encoder_if.slave   bus,
  output logic [CW-1:0]     count,
  output logic              err
);

  r_fields_t   fields;
  logic        full;
  logic        accept;
  logic        push;
  logic        pop;
  logic [31:0] addr_q;
  logic [31:0] instr;
  logic [63:0] head;

  assign fields = rak_fields(bus.in_kind);
  assign instr  = {fields.funct7, bus.in_rs2, bus.in_rs1, fields.funct3, bus.in_rd, OPCODE_OP};

  assign bus.in_ready  = !full;
  assign bus.out_valid = (count != '0);
  assign accept = bus.in_valid && bus.in_ready;
  assign push   = accept && fields.legal;
  assign pop    = bus.out_valid && bus.out_ready;

  assign bus.out_addr  = head[63:32];
  assign bus.out_instr = head[31:0];

  r_type_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .wdata ({addr_q, instr}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .count (count)
  );

  // The address only advances for words actually stored; it wraps modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      addr_q <= BASE_ADDR;
      err    <= 1'b0;
    end else begin
      if (push) addr_q <= addr_q + 32'd4;
      if (accept && !fields.legal) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_r_type_encoder.sv
// Directed bench for r_type_encoder: drivers push expected {addr, instr} into queues,
// monitors compare every presented output word against the queue head.
module tb_r_type_encoder;
  import opcode_type::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic flush0;
  logic flush1;
  assign flush1 = 1'b0;

  r_type_encoder_if b0 ();
  r_type_encoder_if b1 ();

  logic [2:0] cnt0, cnt1;
  logic       err0, err1;

  r_type_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_0000)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0), .bus(b0), .count(cnt0), .err(err0)
  );

  r_type_encoder #(.DEPTH(4), .BASE_ADDR(32'hFFFF_FFF8)) dut1 (
    .clk(clk), .rst(rst), .flush(flush1), .bus(b1), .count(cnt1), .err(err1)
  );

  // Shared driver signals; sel steers the request to dut0 (0) or dut1 (1).
  logic            sel;
  logic            drv_valid;
  reg_arith_kind_t drv_kind;
  logic [4:0]      drv_rd, drv_rs1, drv_rs2;
  logic            out_rdy;

  assign b0.in_valid  = drv_valid && !sel;
  assign b1.in_valid  = drv_valid && sel;
  assign b0.in_kind   = drv_kind;
  assign b1.in_kind   = drv_kind;
  assign b0.in_rd     = drv_rd;
  assign b1.in_rd     = drv_rd;
  assign b0.in_rs1    = drv_rs1;
  assign b1.in_rs1    = drv_rs1;
  assign b0.in_rs2    = drv_rs2;
  assign b1.in_rs2    = drv_rs2;
  assign b0.out_ready = out_rdy;
  assign b1.out_ready = out_rdy;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];
  logic [31:0] exp_addr0;
  logic [31:0] exp_addr1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: every presented word must match the head; popped only on a handshake.
  always @(negedge clk) begin
    if (!rst && !flush0 && b0.out_valid) begin
      if (exp_q0.size() == 0) begin
        tests++; fails++;
        $display("FAIL mon0_unexpected: got %h expected no word", {b0.out_addr, b0.out_instr});
      end else begin
        check("mon0_word", {b0.out_addr, b0.out_instr}, exp_q0[0]);
        if (b0.out_ready) void'(exp_q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b1.out_valid) begin
      if (exp_q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL mon1_unexpected: got %h expected no word", {b1.out_addr, b1.out_instr});
      end else begin
        check("mon1_word", {b1.out_addr, b1.out_instr}, exp_q1[0]);
        if (b1.out_ready) void'(exp_q1.pop_front());
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; drv_valid = 1'b0; out_rdy = 1'b0; flush0 = 1'b0; sel = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    exp_addr0 = 32'h0000_0000;
    exp_addr1 = 32'hFFFF_FFF8;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one request, waits (bounded) for in_ready, completes on the next edge.
  task automatic push(input bit s, input reg_arith_kind_t k, input logic [4:0] d,
                      input logic [4:0] a, input logic [4:0] b,
                      input logic [31:0] exp_instr, input bit legal);
    bit ok;
    ok = 1'b0;
    sel = s; drv_kind = k; drv_rd = d; drv_rs1 = a; drv_rs2 = b;
    drv_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s ? b1.in_ready : b0.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL push_timeout: got in_ready=0 expected 1 within 50 cycles");
    end else if (legal) begin
      if (s) begin
        exp_q1.push_back({exp_addr1, exp_instr});
        exp_addr1 = exp_addr1 + 32'd4;
      end else begin
        exp_q0.push_back({exp_addr0, exp_instr});
        exp_addr0 = exp_addr0 + 32'd4;
      end
    end
    @(posedge clk);
    #1 drv_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    drv_kind = rak_add; drv_rd = '0; drv_rs1 = '0; drv_rs2 = '0;

    // Reset state
    do_reset();
    check("rst_count", cnt0, 0);
    check("rst_out_valid", b0.out_valid, 0);
    check("rst_in_ready", b0.in_ready, 1);
    check("rst_err", err0, 0);
    check("rst_out_instr", b0.out_instr, 0);
    check("rst_out_addr", b0.out_addr, 0);

    // Single word, one-cycle latency
    out_rdy = 1'b0;
    push(0, rak_add, 5'd1, 5'd2, 5'd3, 32'h003100B3, 1);
    check("single_count", cnt0, 1);
    check("single_valid", b0.out_valid, 1);
    check("single_instr", b0.out_instr, 32'h003100B3);
    check("single_addr", b0.out_addr, 32'h0000_0000);
    out_rdy = 1'b1;
    idle(2);
    check("single_drained", cnt0, 0);

    // Back-to-back with out_ready high
    do_reset();
    out_rdy = 1'b1;
    push(0, rak_sub, 5'd5, 5'd6, 5'd7, 32'h407302B3, 1);
    push(0, rak_sra, 5'd10, 5'd11, 5'd12, 32'h40C5D533, 1);
    push(0, rak_and, 5'd31, 5'd31, 5'd31, 32'h01FFFFB3, 1);
    idle(3);
    check("b2b_count", cnt0, 0);
    check("b2b_q_empty", exp_q0.size(), 0);

    // Backpressure: fill, stall the 5th request, then drain
    do_reset();
    out_rdy = 1'b0;
    push(0, rak_xor, 5'd1, 5'd2, 5'd3, 32'h003140B3, 1);
    push(0, rak_or,  5'd1, 5'd2, 5'd3, 32'h003160B3, 1);
    push(0, rak_sll, 5'd4, 5'd5, 5'd6, 32'h00629233, 1);
    push(0, rak_slt, 5'd1, 5'd2, 5'd3, 32'h003120B3, 1);
    check("full_in_ready", b0.in_ready, 0);
    check("full_count", cnt0, 4);
    fork
      push(0, rak_sltu, 5'd1, 5'd2, 5'd3, 32'h003130B3, 1);
      begin
        repeat (3) @(negedge clk);
        check("stall_count", cnt0, 4);
        check("stall_in_ready", b0.in_ready, 0);
        @(posedge clk);
        #1 out_rdy = 1'b1;
      end
    join
    idle(6);
    check("bp_count", cnt0, 0);
    check("bp_q_empty", exp_q0.size(), 0);

    // Illegal kind between two adds
    do_reset();
    out_rdy = 1'b1;
    push(0, rak_add, 5'd1, 5'd2, 5'd3, 32'h003100B3, 1);
    push(0, reg_arith_kind_t'(4'd12), 5'd1, 5'd2, 5'd3, 32'h0, 0);
    check("illegal_err", err0, 1);
    push(0, rak_add, 5'd7, 5'd8, 5'd9, 32'h009403B3, 1);
    idle(3);
    check("illegal_err_sticky", err0, 1);
    check("illegal_count", cnt0, 0);
    check("illegal_q_empty", exp_q0.size(), 0);

    // Flush with 3 pending and a simultaneous push
    do_reset();
    out_rdy = 1'b0;
    push(0, reg_arith_kind_t'(4'd15), 5'd0, 5'd0, 5'd0, 32'h0, 0);
    push(0, rak_add, 5'd1, 5'd2, 5'd3, 32'h003100B3, 1);
    push(0, rak_sub, 5'd5, 5'd6, 5'd7, 32'h407302B3, 1);
    push(0, rak_xor, 5'd1, 5'd2, 5'd3, 32'h003140B3, 1);
    check("preflush_count", cnt0, 3);
    check("preflush_err", err0, 1);
    sel = 1'b0; drv_kind = rak_or; drv_rd = 5'd1; drv_rs1 = 5'd2; drv_rs2 = 5'd3;
    drv_valid = 1'b1; flush0 = 1'b1;
    exp_q0.delete();
    @(posedge clk);
    #1 flush0 = 1'b0; drv_valid = 1'b0;
    exp_addr0 = 32'h0000_0000;
    check("flush_count", cnt0, 0);
    check("flush_err", err0, 0);
    check("flush_out_valid", b0.out_valid, 0);
    out_rdy = 1'b1;
    push(0, rak_add, 5'd7, 5'd8, 5'd9, 32'h009403B3, 1);
    idle(3);
    check("postflush_q_empty", exp_q0.size(), 0);

    // Address wrap on the high-base instance
    do_reset();
    out_rdy = 1'b1;
    push(1, rak_add, 5'd1, 5'd2, 5'd3, 32'h003100B3, 1);
    push(1, rak_srl, 5'd1, 5'd2, 5'd3, 32'h003150B3, 1);
    push(1, rak_sub, 5'd5, 5'd6, 5'd7, 32'h407302B3, 1);
    check("wrap_next_addr", exp_addr1, 32'h0000_0004);
    idle(3);
    check("wrap_count", cnt1, 0);
    check("wrap_q_empty", exp_q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
